// File: rtl/fuse_ctrl_pkg.sv
// fuse_ctrl_pkg: shared types and constants for the fuse read sequencer.
//   fuse_state_e        sequencer states
//   FUSE_T_*            default macro timing, in clock cycles
//   fuse_row_w()        row-address width for a given fuse array depth
//   fuse_cnt_w()        width of the shared phase down-counter
package fuse_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StDone
    } fuse_state_e;

    localparam int unsigned FUSE_MEM_SIZE_DEF = 34;
    localparam int unsigned FUSE_T_SETUP      = 2;
    localparam int unsigned FUSE_T_STROBE     = 4;
    localparam int unsigned FUSE_T_HOLD       = 1;

    function automatic int unsigned fuse_row_w(input int unsigned size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    // Counter is loaded with T-1, so it only needs to hold max(T)-1.
    function automatic int unsigned fuse_cnt_w(input int unsigned a, input int unsigned b,
                                               input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int unsigned FUSE_ROW_W = fuse_row_w(FUSE_MEM_SIZE_DEF);

endpackage

// File: rtl/fuse_ctrl.sv
// fuse_ctrl: read sequencer in front of the OTP fuse macro.
// Turns a level request plus word address into a timed macro access
// (cs -> setup -> strobe -> hold), range-checks the address and caches the
// last good address so a held request does not re-read the macro.
//   clk_i, rst_ni        clock, async active-low reset
//   req_i, addr_i        level request and fuse word index
//   rdata_o, err_o       last completed result (err_o: address out of range)
//   valid_o              one-cycle pulse when rdata_o/err_o update
//   busy_o               sequencer not idle
//   fuse_cs_o/strobe_o/row_o, fuse_dout_i   fuse macro interface
module fuse_ctrl
    import fuse_ctrl_pkg::*;
#(
    parameter int unsigned FUSE_MEM_SIZE = FUSE_MEM_SIZE_DEF,
    parameter int unsigned T_SETUP       = FUSE_T_SETUP,
    parameter int unsigned T_STROBE      = FUSE_T_STROBE,
    parameter int unsigned T_HOLD        = FUSE_T_HOLD
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 req_i,
    input  logic [31:0]                          addr_i,
    output logic [31:0]                          rdata_o,
    output logic                                 valid_o,
    output logic                                 busy_o,
    output logic                                 err_o,
    output logic                                 fuse_cs_o,
    output logic                                 fuse_strobe_o,
    output logic [fuse_row_w(FUSE_MEM_SIZE)-1:0] fuse_row_o,
    input  logic [31:0]                          fuse_dout_i
);

    localparam int unsigned RowW = fuse_row_w(FUSE_MEM_SIZE);
    localparam int unsigned CntW = fuse_cnt_w(T_SETUP, T_STROBE, T_HOLD);

    fuse_state_e       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       res_q, res_d;
    logic              res_err_q, res_err_d;
    logic              cache_vld_q, cache_vld_d;
    logic [31:0]       cache_addr_q, cache_addr_d;

    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              cs_q, cs_d;
    logic              strobe_q, strobe_d;
    logic [RowW-1:0]   row_q, row_d;
    logic              active_d;

    // State register and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            addr_q       <= '0;
            res_q        <= '0;
            res_err_q    <= 1'b0;
            cache_vld_q  <= 1'b0;
            cache_addr_q <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            cs_q         <= 1'b0;
            strobe_q     <= 1'b0;
            row_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            res_q        <= res_d;
            res_err_q    <= res_err_d;
            cache_vld_q  <= cache_vld_d;
            cache_addr_q <= cache_addr_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            cs_q         <= cs_d;
            strobe_q     <= strobe_d;
            row_q        <= row_d;
        end
    end

    // Next-state logic; one down-counter times every timed phase.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        res_d        = res_q;
        res_err_d    = res_err_q;
        cache_vld_d  = cache_vld_q;
        cache_addr_d = cache_addr_q;
        unique case (state_q)
            StIdle: begin
                if (req_i && (!cache_vld_q || (addr_i != cache_addr_q))) begin
                    addr_d = addr_i;
                    if (addr_i >= 32'(FUSE_MEM_SIZE)) begin
                        // Out of range: never touch the macro.
                        state_d   = StDone;
                        res_d     = '0;
                        res_err_d = 1'b1;
                    end else begin
                        state_d   = StSetup;
                        cnt_d     = CntW'(T_SETUP - 1);
                        res_err_d = 1'b0;
                    end
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StStrobe;
                    cnt_d   = CntW'(T_STROBE - 1);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    res_d   = fuse_dout_i;
                    state_d = StHold;
                    cnt_d   = CntW'(T_HOLD - 1);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                state_d      = StIdle;
                cache_addr_d = addr_q;
                cache_vld_d  = !res_err_q;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        active_d = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);
        cs_d     = active_d;
        strobe_d = (state_d == StStrobe);
        row_d    = active_d ? addr_d[RowW-1:0] : '0;
        busy_d   = (state_d != StIdle);
        valid_d  = (state_d == StDone);
        rdata_d  = valid_d ? res_d : rdata_q;
        err_d    = valid_d ? res_err_d : err_q;
    end

    assign rdata_o       = rdata_q;
    assign err_o         = err_q;
    assign valid_o       = valid_q;
    assign busy_o        = busy_q;
    assign fuse_cs_o     = cs_q;
    assign fuse_strobe_o = strobe_q;
    assign fuse_row_o    = row_q;

endmodule

// File: tb/tb_fuse_ctrl.sv
module tb_fuse_ctrl;

    localparam int unsigned SIZE = 34;
    localparam int unsigned TS   = 2;
    localparam int unsigned TST  = 4;
    localparam int unsigned TH   = 1;
    localparam int          LIN  = TS + TST + TH + 1;

    logic        clk;
    logic        rst_ni;
    logic        req_i;
    logic [31:0] addr_i;
    logic [31:0] rdata_o;
    logic        valid_o;
    logic        busy_o;
    logic        err_o;
    logic        fuse_cs_o;
    logic        fuse_strobe_o;
    logic [5:0]  fuse_row_o;
    logic [31:0] fuse_dout_i;

    fuse_ctrl #(
        .FUSE_MEM_SIZE(SIZE),
        .T_SETUP      (TS),
        .T_STROBE     (TST),
        .T_HOLD       (TH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .addr_i       (addr_i),
        .rdata_o      (rdata_o),
        .valid_o      (valid_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .fuse_cs_o    (fuse_cs_o),
        .fuse_strobe_o(fuse_strobe_o),
        .fuse_row_o   (fuse_row_o),
        .fuse_dout_i  (fuse_dout_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Fuse array contents seen through the macro model.
    logic [31:0] mem [SIZE];
    int          strobe_run;

    // Reference model: an access is a fixed-length timeline counted from
    // the clock edge at which it starts.
    int          m_k;
    bit          m_inr;
    logic [31:0] m_addr;
    logic [31:0] m_rdata;
    bit          m_err;
    bit          m_cvld;
    logic [31:0] m_caddr;

    function automatic int m_len();
        return m_inr ? LIN : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_k = 0; m_inr = 0; m_addr = '0; m_rdata = '0; m_err = 0; m_cvld = 0; m_caddr = '0;
    endtask

    task automatic model_complete();
        m_rdata = m_inr ? mem[m_addr] : 32'h0;
        m_err   = !m_inr;
        m_caddr = m_addr;
        m_cvld  = m_inr;
    endtask

    task automatic model_edge();
        if (!rst_ni) begin
            model_reset();
        end else if (m_k > 0) begin
            if (m_k == m_len()) begin
                m_k = 0;
            end else begin
                m_k++;
                if (m_k == m_len()) model_complete();
            end
        end else if (req_i && !(m_cvld && addr_i == m_caddr)) begin
            m_addr = addr_i;
            m_inr  = addr_i < SIZE;
            m_k    = 1;
            if (m_k == m_len()) model_complete();
        end
    endtask

    task automatic check_all();
        logic        e_cs, e_st, e_valid;
        logic [5:0]  e_row;
        e_cs    = (m_k > 0) && m_inr && (m_k <= LIN - 1);
        e_st    = m_inr && (m_k > TS) && (m_k <= TS + TST);
        e_row   = e_cs ? m_addr[5:0] : 6'd0;
        e_valid = (m_k > 0) && (m_k == m_len());
        chk("cs", 32'(fuse_cs_o), 32'(e_cs));
        chk("strobe", 32'(fuse_strobe_o), 32'(e_st));
        chk("row", 32'(fuse_row_o), 32'(e_row));
        chk("busy", 32'(busy_o), 32'(m_k > 0));
        chk("valid", 32'(valid_o), 32'(e_valid));
        chk("rdata", rdata_o, m_rdata);
        chk("err", 32'(err_o), 32'(m_err));
        // Macro model: only the last strobe cycle carries the true word.
        if (fuse_strobe_o === 1'b1) strobe_run++;
        else strobe_run = 0;
        if (fuse_strobe_o === 1'b1 && fuse_row_o < SIZE)
            fuse_dout_i = (strobe_run == TST) ? mem[fuse_row_o] : ~mem[fuse_row_o];
        else
            fuse_dout_i = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Issue one request from idle and measure the cycles to valid_o.
    task automatic run_vec(input logic [31:0] a, input int lat, input logic [31:0] rd,
                           input bit er);
        int  n;
        bit  got;
        req_i = 1'b0;
        step();
        req_i  = 1'b1;
        addr_i = a;
        n      = 0;
        got    = 0;
        while (n < 20 && !got) begin
            step();
            n++;
            if (valid_o === 1'b1) got = 1;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("vec_rdata", rdata_o, rd);
        chk("vec_err", 32'(err_o), 32'(er));
    endtask

    typedef struct {
        logic [31:0] addr;
        int          lat;
        logic [31:0] rdata;
        bit          err;
    } vec_t;

    initial begin
        vec_t vecs [9];
        int   cs_cnt, v_cnt;

        vecs[0] = '{32'd3,          8, 32'hA5A5_0003, 1'b0};
        vecs[1] = '{32'd33,         8, 32'hA5A5_0021, 1'b0};
        vecs[2] = '{32'd34,         1, 32'h0,         1'b1};
        vecs[3] = '{32'd34,         1, 32'h0,         1'b1};
        vecs[4] = '{32'd0,          8, 32'hA5A5_0000, 1'b0};
        vecs[5] = '{32'd35,         1, 32'h0,         1'b1};
        vecs[6] = '{32'hFFFF_FFFF,  1, 32'h0,         1'b1};
        vecs[7] = '{32'd33,         8, 32'hA5A5_0021, 1'b0};
        vecs[8] = '{32'd20,         8, 32'hA5A5_0014, 1'b0};

        for (int i = 0; i < int'(SIZE); i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        strobe_run  = 0;
        fuse_dout_i = '0;
        req_i       = 1'b0;
        addr_i      = '0;
        rst_ni      = 1'b0;
        model_reset();
        #1;
        check_all();
        step();
        step();
        @(negedge clk);
        rst_ni = 1'b1;

        // First access to row 5, then a long held request that must hit the cache.
        run_vec(32'd5, 8, 32'hA5A5_0005, 1'b0);
        cs_cnt = 0;
        v_cnt  = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (fuse_cs_o === 1'b1) cs_cnt++;
            if (valid_o === 1'b1) v_cnt++;
        end
        chk("held_cs", 32'(cs_cnt), 32'd0);
        chk("held_valid", 32'(v_cnt), 32'd0);
        chk("held_rdata", rdata_o, 32'hA5A5_0005);

        for (int i = 0; i < 9; i++) run_vec(vecs[i].addr, vecs[i].lat, vecs[i].rdata, vecs[i].err);

        // Address changes 5 -> 7 mid-access: both reads complete in order.
        req_i = 1'b0;
        step();
        req_i  = 1'b1;
        addr_i = 32'd5;
        v_cnt  = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 2) addr_i = 32'd7;
            if (valid_o === 1'b1) v_cnt++;
            if (i == 7) chk("chg_first", rdata_o, 32'hA5A5_0005);
        end
        chk("chg_valids", 32'(v_cnt), 32'd2);
        chk("chg_rdata", rdata_o, 32'hA5A5_0007);

        // Request dropped mid-access: the access still finishes, nothing follows.
        req_i = 1'b0;
        step();
        req_i  = 1'b1;
        addr_i = 32'd11;
        v_cnt  = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 3) req_i = 1'b0;
            if (valid_o === 1'b1) v_cnt++;
        end
        chk("drop_valids", 32'(v_cnt), 32'd1);
        chk("drop_rdata", rdata_o, 32'hA5A5_000B);

        // Asynchronous reset during strobe, then the same address re-reads.
        req_i  = 1'b1;
        addr_i = 32'd9;
        for (int i = 0; i < TS + 2; i++) step();
        chk("pre_rst_strobe", 32'(fuse_strobe_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_all();
        step();
        @(negedge clk);
        rst_ni = 1'b1;
        v_cnt  = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (valid_o === 1'b1) v_cnt++;
        end
        chk("rst_refetch_valid", 32'(v_cnt), 32'd1);
        chk("rst_refetch_rdata", rdata_o, 32'hA5A5_0009);

        // Random traffic against the model, with a small address pool so the
        // cache both hits and misses.
        for (int i = 0; i < 600; i++) begin
            step();
            if ($urandom_range(0, 3) != 0) req_i = 1'b1;
            else req_i = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 9) == 0) addr_i = $urandom;
                else addr_i = 32'($urandom_range(28, 38));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
